accel_tilt_sequencer: RTL and testbench
=======================================

// Module: accel_tilt_sequencer
// PURPOSE
// Upstream/downstream sequencer around the shared arctan CORDIC in the MPU6050 attitude path.
// - Takes one accelerometer sample (ax, ay, az) and issues two CORDIC jobs.
// - Job 1 computes roll = atan(ay/az) and the YZ magnitude.
// - Job 2 computes pitch = atan(-ax / |ayz|).
// - Registers both angles (deg*2^16) for the attitude filter.
// PARAMETERS
// DW           16   accel sample width, signed
// TIMEOUT_CYC  32   max cycles waited for cordic_ack per job; must be > 17
// PORTS
// clk           in   1   system clock
// rst           in   1   synchronous, active-high reset
// sample_valid  in   1   accel sample present
// sample_ready  out  1   high only in IDLE; accept = valid & ready
// acc_x/y/z     in   DW  signed accel axes, latched on accept
// cordic_req    out  1   one-cycle job request to CORDIC
// cordic_x      out  16  signed CORDIC X operand, held until the next request
// cordic_y      out  16  signed CORDIC Y operand, held until the next request
// cordic_ack    in   1   CORDIC result strobe, 17 cycles after cordic_req
// cordic_theta  in   32  signed angle, deg*2^16, valid with ack
// cordic_amp    in   16  magnitude (approx. gain 1.03), valid with ack
// roll          out  32  signed deg*2^16, registered
// pitch         out  32  signed deg*2^16, registered
// angle_valid   out  1   one-cycle pulse when roll/pitch update
// timeout_err   out  1   one-cycle pulse, job abandoned
// BEHAVIOUR
// - Reset: state IDLE; roll=pitch=0; cordic_x=cordic_y=0; cordic_req, angle_valid, timeout_err=0; counter=0.
// - Reset mid-job aborts without an angle_valid pulse.
// - FSM: IDLE -> ROLL_REQ -> ROLL_WAIT -> PITCH_REQ -> PITCH_WAIT -> DONE -> IDLE.
// - IDLE: on accept, latch axes.
//   - ay==0 && az==0: roll_r=0, mag=0, go to PITCH_REQ.
//   - Otherwise go to ROLL_REQ.
// - ROLL_REQ: cordic_req=1 for exactly 1 cycle, cordic_x=az, cordic_y=ay; go to ROLL_WAIT.
// - ROLL_WAIT: on ack, roll_r<=theta, mag<=amp-(amp>>5) for gain correction, go to PITCH_REQ.
// - PITCH_REQ:
//   - mag==0 && ax==0: pitch_r=0, go to DONE, no request.
//   - Otherwise: cordic_req=1, cordic_x=min(mag,32767), cordic_y=-ax saturated (-32768 -> 32767).
// - PITCH_WAIT: on ack, pitch_r<=theta, go to DONE.
// - DONE: roll<=roll_r, pitch<=pitch_r, angle_valid=1; go to IDLE.
// - Wait counter:
//   - Clears on entering each WAIT state and increments each WAIT cycle.
//   - At TIMEOUT_CYC without ack: timeout_err=1, go to IDLE, roll/pitch unchanged.
// - cordic_ack outside the WAIT states is ignored; no state change.
// - Latency from accept (cycle 0), 17-cycle CORDIC:
//   - Roll req at cycle 1, roll ack at cycle 18.
//   - Pitch req at cycle 19, pitch ack at cycle 36.
//   - angle_valid at cycle 37; sample_ready high again at cycle 38.
// - Roll range is +/-90 deg: the CORDIC folds X<0 into quadrants I/IV. Quadrant unfolding is downstream.
// - No overlap: one job outstanding at a time. sample_valid held high gives back-to-back accepts every 38 cycles.
// TESTING
// - ax=0, ay=0, az=16384 -> roll within +/-6554 (0.1 deg) of 0; pitch within +/-32768 (0.5 deg) of 0; angle_valid at cycle 37.
// - ax=0, ay=16384, az=16384 -> roll within +/-6554 of 2949120 (45 deg); pitch within +/-32768 of 0.
// - ax=16384, ay=0, az=16384 -> roll within +/-6554 of 0; pitch within +/-32768 of -2949120 (-45 deg).
// - ax=ay=az=0 -> no cordic_req; roll=pitch=0; angle_valid at cycle 2.
// - CORDIC model never acks -> timeout_err TIMEOUT_CYC cycles into ROLL_WAIT; no angle_valid; sample_ready next cycle; stray ack afterwards is ignored.
// - ax=-32768 -> cordic_y=32767 in pitch job.
// - rst pulsed at cycle 10 -> cordic_req never rises again; outputs all 0; next sample completes normally.

Source files
------------

// File: rtl/accel_tilt_sequencer.sv
// accel_tilt_sequencer
// Takes one accelerometer sample and runs two jobs on the shared arctan CORDIC.
// The first job gives roll and the YZ magnitude. The second job gives pitch
// from -ax and the gain-corrected magnitude. Both angles are registered
// together for the attitude filter.
module accel_tilt_sequencer #(
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic signed [DW-1:0] acc_x_i,
    input  logic signed [DW-1:0] acc_y_i,
    input  logic signed [DW-1:0] acc_z_i,
    output logic                 cordic_req_o,
    output logic signed [15:0]   cordic_x_o,
    output logic signed [15:0]   cordic_y_o,
    input  logic                 cordic_ack_i,
    input  logic signed [31:0]   cordic_theta_i,
    input  logic        [15:0]   cordic_amp_i,
    output logic signed [31:0]   roll_o,
    output logic signed [31:0]   pitch_o,
    output logic                 angle_valid_o,
    output logic                 timeout_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        ROLL_REQ,
        ROLL_WAIT,
        PITCH_REQ,
        PITCH_WAIT,
        DONE
    } state_e;

    localparam int NW = ((DW > 16) ? DW : 16) + 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [NW-1:0] SatHi = NW'(32767);
    localparam logic signed [NW-1:0] SatLo = -NW'(32768);

    state_e                state_q;
    logic signed [DW-1:0]  accX_q;
    logic        [15:0]    mag_q;
    logic signed [31:0]    rollR_q;
    logic        [CW-1:0]  waitCnt_q;

    logic signed [DW-1:0]  pitchAxSrc;
    logic        [15:0]    pitchMagSrc;
    logic        [15:0]    magNext_d;
    logic signed [NW-1:0]  negAx_d;
    logic signed [15:0]    pitchX_d;
    logic signed [15:0]    pitchY_d;
    logic                  pitchSkip_d;
    logic                  yzZero;

    // Clamp a widened signed value into the 16-bit CORDIC operand range.
    function automatic logic signed [15:0] sat16(input logic signed [NW-1:0] v);
        if (v > SatHi) begin
            return 16'sh7FFF;
        end else if (v < SatLo) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    assign sample_ready_o = (state_q == IDLE);
    assign yzZero         = (acc_y_i == '0) && (acc_z_i == '0);

    // Prepare the pitch-job operands for whichever path enters PITCH_REQ next.
    always_comb begin
        magNext_d = cordic_amp_i - (cordic_amp_i >> 5);
        if (state_q == IDLE) begin
            pitchAxSrc  = acc_x_i;
            pitchMagSrc = '0;
        end else begin
            pitchAxSrc  = accX_q;
            pitchMagSrc = magNext_d;
        end
        negAx_d     = -(NW'(pitchAxSrc));
        pitchX_d    = pitchMagSrc[15] ? 16'sh7FFF : $signed(pitchMagSrc);
        pitchY_d    = sat16(negAx_d);
        pitchSkip_d = (pitchMagSrc == '0) && (pitchAxSrc == '0);
    end

    // Sequencer FSM with registered request, operand, angle and strobe outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            accX_q        <= '0;
            mag_q         <= '0;
            rollR_q       <= '0;
            waitCnt_q     <= '0;
            cordic_req_o  <= 1'b0;
            cordic_x_o    <= '0;
            cordic_y_o    <= '0;
            roll_o        <= '0;
            pitch_o       <= '0;
            angle_valid_o <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            cordic_req_o  <= 1'b0;
            angle_valid_o <= 1'b0;
            timeout_err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_valid_i) begin
                        accX_q <= acc_x_i;
                        if (yzZero) begin
                            rollR_q      <= '0;
                            mag_q        <= '0;
                            state_q      <= PITCH_REQ;
                            cordic_req_o <= !pitchSkip_d;
                            if (!pitchSkip_d) begin
                                cordic_x_o <= pitchX_d;
                                cordic_y_o <= pitchY_d;
                            end
                        end else begin
                            state_q      <= ROLL_REQ;
                            cordic_req_o <= 1'b1;
                            cordic_x_o   <= sat16(NW'(acc_z_i));
                            cordic_y_o   <= sat16(NW'(acc_y_i));
                        end
                    end
                end
                ROLL_REQ: begin
                    waitCnt_q <= '0;
                    state_q   <= ROLL_WAIT;
                end
                ROLL_WAIT, PITCH_WAIT: begin
                    if (waitCnt_q == CW'(TIMEOUT_CYC)) begin
                        state_q <= IDLE;
                    end else if (cordic_ack_i) begin
                        if (state_q == ROLL_WAIT) begin
                            rollR_q      <= cordic_theta_i;
                            mag_q        <= magNext_d;
                            state_q      <= PITCH_REQ;
                            cordic_req_o <= !pitchSkip_d;
                            if (!pitchSkip_d) begin
                                cordic_x_o <= pitchX_d;
                                cordic_y_o <= pitchY_d;
                            end
                        end else begin
                            roll_o        <= rollR_q;
                            pitch_o       <= cordic_theta_i;
                            angle_valid_o <= 1'b1;
                            state_q       <= DONE;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                        if (waitCnt_q == CW'(TIMEOUT_CYC - 1)) begin
                            timeout_err_o <= 1'b1;
                        end
                    end
                end
                PITCH_REQ: begin
                    if ((mag_q == '0) && (accX_q == '0)) begin
                        roll_o        <= rollR_q;
                        pitch_o       <= '0;
                        angle_valid_o <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        waitCnt_q <= '0;
                        state_q   <= PITCH_WAIT;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_tilt_sequencer.sv
// Testbench for accel_tilt_sequencer: behavioural 17-cycle CORDIC model,
// scoreboard of expected angles/latencies, timeout, stray-ack and reset cases.
module tb_accel_tilt_sequencer;

    localparam int  DW          = 16;
    localparam int  TIMEOUT_CYC = 32;
    localparam real PI          = 3.14159265358979;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_valid;
    logic                 sample_ready;
    logic signed [DW-1:0] acc_x, acc_y, acc_z;
    logic                 cordic_req;
    logic signed [15:0]   cordic_x, cordic_y;
    logic                 cordic_ack;
    logic signed [31:0]   cordic_theta;
    logic        [15:0]   cordic_amp;
    logic signed [31:0]   roll, pitch;
    logic                 angle_valid;
    logic                 timeout_err;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycleCnt    = 0;

    typedef struct {
        longint rollExp;
        longint rollTol;
        longint pitchExp;
        longint pitchTol;
        int     latency;
        int     acceptCycle;
    } expT;

    expT sb[$];

    int                 reqCount = 0;
    int                 reqCycle[$];
    logic signed [15:0] reqX[$];
    logic signed [15:0] reqY[$];
    bit                 noAck         = 1'b0;
    bit                 strayPulse    = 1'b0;
    bit                 expectTimeout = 1'b0;

    accel_tilt_sequencer #(.DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .acc_x_i        (acc_x),
        .acc_y_i        (acc_y),
        .acc_z_i        (acc_z),
        .cordic_req_o   (cordic_req),
        .cordic_x_o     (cordic_x),
        .cordic_y_o     (cordic_y),
        .cordic_ack_i   (cordic_ack),
        .cordic_theta_i (cordic_theta),
        .cordic_amp_i   (cordic_amp),
        .roll_o         (roll),
        .pitch_o        (pitch),
        .angle_valid_o  (angle_valid),
        .timeout_err_o  (timeout_err)
    );

    // Free-running clock and a cycle counter used for latency bookkeeping.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint observed,
                               input longint expected, input longint tol);
        longint diff;
        totalChecks++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    function automatic longint modelTheta(input int x, input int y);
        real a;
        if (x == 0 && y == 0) return 0;
        if (x >= 0) a = $atan2(real'(y), real'(x));
        else        a = $atan(real'(y) / real'(x));
        a = a * 180.0 / PI * 65536.0;
        if (a >= 0.0) return longint'($rtoi(a + 0.5));
        else          return longint'($rtoi(a - 0.5));
    endfunction

    function automatic int modelAmp(input int x, input int y);
        real rx, ry;
        int  r;
        rx = x;
        ry = y;
        r  = $rtoi(1.03 * $sqrt(rx * rx + ry * ry) + 0.5);
        if (r > 65535) r = 65535;
        return r;
    endfunction

    // Behavioural CORDIC: result strobe 17 cycles after each request.
    initial begin
        int               countdown;
        logic signed [31:0] pendTheta;
        logic        [15:0] pendAmp;
        countdown    = 0;
        pendTheta    = '0;
        pendAmp      = '0;
        cordic_ack   = 1'b0;
        cordic_theta = '0;
        cordic_amp   = '0;
        forever begin
            @(negedge clk);
            cordic_ack = 1'b0;
            if (strayPulse) begin
                cordic_ack   = 1'b1;
                cordic_theta = 32'sd123456;
                cordic_amp   = 16'd999;
                strayPulse   = 1'b0;
            end
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    cordic_ack   = 1'b1;
                    cordic_theta = pendTheta;
                    cordic_amp   = pendAmp;
                end
            end
            if (cordic_req) begin
                reqCount++;
                reqCycle.push_back(cycleCnt);
                reqX.push_back(cordic_x);
                reqY.push_back(cordic_y);
                if (!noAck) begin
                    pendTheta = 32'(modelTheta(int'(cordic_x), int'(cordic_y)));
                    pendAmp   = 16'(modelAmp(int'(cordic_x), int'(cordic_y)));
                    countdown = 17;
                end
            end
        end
    end

    // Scoreboard consumer: compare every angle_valid pulse with the oldest expectation.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (angle_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 1, 0, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("roll", longint'(roll), e.rollExp, e.rollTol);
                    checkOutput("pitch", longint'(pitch), e.pitchExp, e.pitchTol);
                    checkOutput("latency", cycleCnt - e.acceptCycle, e.latency, 0);
                end
            end
            if (timeout_err && !expectTimeout) checkOutput("spurious_timeout", 1, 0, 0);
        end
    end

    task automatic applyStimulus(input int ax, input int ay, input int az,
                                 input bit wantResult,
                                 input longint rollExp, input longint rollTol,
                                 input longint pitchExp, input longint pitchTol,
                                 input int latency, output int acceptCycle);
        expT e;
        int  n;
        acceptCycle = -1;
        @(negedge clk);
        n = 0;
        while (!sample_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            checkOutput("ready_wait", 0, 1, 0);
            return;
        end
        acc_x        = 16'(ax);
        acc_y        = 16'(ay);
        acc_z        = 16'(az);
        sample_valid = 1'b1;
        acceptCycle  = cycleCnt;
        if (wantResult) begin
            e.rollExp     = rollExp;
            e.rollTol     = rollTol;
            e.pitchExp    = pitchExp;
            e.pitchTol    = pitchTol;
            e.latency     = latency;
            e.acceptCycle = acceptCycle;
            sb.push_back(e);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0, 0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int     acc;
        int     snap;
        int     n;
        int     tCycle;
        int     expAmp;
        int     expMag;
        longint expPitch;

        rst          = 1'b1;
        sample_valid = 1'b0;
        acc_x        = '0;
        acc_y        = '0;
        acc_z        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ready", sample_ready, 1, 0);
        checkOutput("rst_req", cordic_req, 0, 0);
        checkOutput("rst_x", cordic_x, 0, 0);
        checkOutput("rst_y", cordic_y, 0, 0);
        checkOutput("rst_roll", roll, 0, 0);
        checkOutput("rst_pitch", pitch, 0, 0);
        checkOutput("rst_valid", angle_valid, 0, 0);
        checkOutput("rst_timeout", timeout_err, 0, 0);

        $display("[TB] level sample");
        applyStimulus(0, 0, 16384, 1'b1, 0, 6554, 0, 32768, 37, acc);
        waitDrain();

        $display("[TB] roll 45 deg");
        applyStimulus(0, 16384, 16384, 1'b1, 2949120, 6554, 0, 32768, 37, acc);
        waitDrain();

        $display("[TB] reset mid-job");
        applyStimulus(0, 16384, 16384, 1'b0, 0, 0, 0, 0, 0, acc);
        while (cycleCnt < acc + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        snap = reqCount;
        checkOutput("midrst_roll", roll, 0, 0);
        checkOutput("midrst_pitch", pitch, 0, 0);
        checkOutput("midrst_req", cordic_req, 0, 0);
        checkOutput("midrst_x", cordic_x, 0, 0);
        checkOutput("midrst_y", cordic_y, 0, 0);
        checkOutput("midrst_ready", sample_ready, 1, 0);
        repeat (60) @(negedge clk);
        checkOutput("midrst_no_req", reqCount, snap, 0);

        $display("[TB] pitch -45 deg");
        applyStimulus(16384, 0, 16384, 1'b1, 0, 6554, -2949120, 32768, 37, acc);
        waitDrain();

        $display("[TB] all-zero sample");
        snap = reqCount;
        applyStimulus(0, 0, 0, 1'b1, 0, 0, 0, 0, 2, acc);
        waitDrain();
        checkOutput("zero_no_req", reqCount, snap, 0);

        $display("[TB] ax at negative full scale");
        snap     = reqCount;
        expAmp   = modelAmp(16384, 0);
        expMag   = expAmp - (expAmp >> 5);
        expPitch = modelTheta(expMag, 32767);
        applyStimulus(-32768, 0, 16384, 1'b1, 0, 6554, expPitch, 32768, 37, acc);
        waitDrain();
        checkOutput("sat_req_count", reqCount - snap, 2, 0);
        if (reqCount - snap == 2) begin
            checkOutput("sat_pitch_y", reqY[snap + 1], 32767, 0);
            checkOutput("sat_pitch_x", reqX[snap + 1], expMag, 0);
            checkOutput("roll_req_cycle", reqCycle[snap] - acc, 1, 0);
            checkOutput("pitch_req_cycle", reqCycle[snap + 1] - acc, 19, 0);
        end

        $display("[TB] timeout and stray ack");
        applyStimulus(0, 0, 0, 1'b1, 0, 0, 0, 0, 2, acc);
        waitDrain();
        noAck         = 1'b1;
        expectTimeout = 1'b1;
        applyStimulus(0, 100, 100, 1'b0, 0, 0, 0, 0, 0, acc);
        n      = 0;
        tCycle = -1;
        while (n < 80 && tCycle < 0) begin
            if (timeout_err) tCycle = cycleCnt;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (tCycle < 0) begin
            checkOutput("timeout_seen", 0, 1, 0);
        end else begin
            checkOutput("timeout_cycle", tCycle - acc, 2 + TIMEOUT_CYC, 0);
            checkOutput("timeout_ready_low", sample_ready, 0, 0);
            @(negedge clk);
            checkOutput("timeout_ready_next", sample_ready, 1, 0);
            checkOutput("timeout_pulse_len", timeout_err, 0, 0);
            checkOutput("timeout_roll", roll, 0, 0);
            checkOutput("timeout_pitch", pitch, 0, 0);
        end
        expectTimeout = 1'b0;
        noAck         = 1'b0;
        snap          = reqCount;
        strayPulse    = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("stray_ready", sample_ready, 1, 0);
        checkOutput("stray_no_req", reqCount, snap, 0);
        checkOutput("stray_roll", roll, 0, 0);

        $display("[TB] recovery sample");
        applyStimulus(0, 16384, 16384, 1'b1, 2949120, 6554, 0, 32768, 37, acc);
        waitDrain();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
